// File: rtl/jogo_pkg.sv
// Shared definitions for the game datapath: detector and control-unit state codes,
// default debounce length and a one-hot helper.
package jogo_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        FILTRA_PRESS   = 3'd1,
        VALIDA         = 3'd2,
        ESPERA_SOLTAR  = 3'd3,
        FILTRA_SOLTURA = 3'd4
    } det_estado_t;

    typedef enum logic [2:0] {
        UC_INICIAL  = 3'd0,
        UC_PREPARA  = 3'd1,
        UC_ESPERA   = 3'd2,
        UC_REGISTRA = 3'd3,
        UC_COMPARA  = 3'd4,
        UC_FIM      = 3'd5
    } uc_estado_t;

    function automatic logic um_bit(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-stage synchronizer for raw asynchronous levels into the clock domain.
module sincronizador_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces the four play buttons and reports one validated play per press/release cycle.
// state          | meaning
// OCIOSO         | idle, waiting for a press while habilita=1
// FILTRA_PRESS   | pressed pattern must stay stable for DEBOUNCE_CYCLES
// VALIDA         | one cycle: emit tem_jogada or jogada_invalida
// ESPERA_SOLTAR  | waiting for all buttons to be released
// FILTRA_SOLTURA | release must stay stable for DEBOUNCE_CYCLES
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic       tem_jogada,
    output logic [3:0] jogada,
    output logic       jogada_invalida,
    output logic [2:0] db_estado
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    bs;
    det_estado_t   estado_q;
    logic [CW-1:0] cont_q;
    logic [3:0]    amostra_q;
    logic [3:0]    jogada_q;
    logic          tem_q;
    logic          inv_q;

    sincronizador_2ff #(.WIDTH(4)) u_sinc (
        .clock   (clock),
        .reset   (reset),
        .async_i (botoes),
        .sync_o  (bs)
    );

    // Pulse flags are set on the edge entering VALIDA, so they are high exactly while in VALIDA.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            amostra_q <= '0;
            jogada_q  <= '0;
            tem_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            tem_q <= 1'b0;
            inv_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (habilita && (bs != 4'd0)) begin
                        amostra_q <= bs;
                        cont_q    <= '0;
                        estado_q  <= FILTRA_PRESS;
                    end
                end
                FILTRA_PRESS: begin
                    if ((bs != amostra_q) || !habilita) begin
                        estado_q <= OCIOSO;
                    end else if (cont_q == CNT_MAX) begin
                        estado_q <= VALIDA;
                        tem_q    <= um_bit(amostra_q);
                        inv_q    <= !um_bit(amostra_q);
                    end else begin
                        cont_q <= cont_q + CW'(1);
                    end
                end
                VALIDA: begin
                    if (um_bit(amostra_q)) begin
                        jogada_q <= amostra_q;
                    end
                    estado_q <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (bs == 4'd0) begin
                        cont_q   <= '0;
                        estado_q <= FILTRA_SOLTURA;
                    end
                end
                FILTRA_SOLTURA: begin
                    if (bs != 4'd0) begin
                        estado_q <= ESPERA_SOLTAR;
                    end else if (cont_q == CNT_MAX) begin
                        estado_q <= OCIOSO;
                    end else begin
                        cont_q <= cont_q + CW'(1);
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign tem_jogada      = tem_q;
    assign jogada_invalida = inv_q;
    assign jogada          = jogada_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: a run-length reference model predicts every pulse
// and the held play code; a monitor compares them against the outputs on each falling edge.
module tb_detector_jogada;
    import jogo_pkg::*;

    localparam int DC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    always #5 clock = ~clock;

    detector_jogada #(.DEBOUNCE_CYCLES(DC)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .tem_jogada      (tem_jogada),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;

    typedef struct {
        bit         valido;
        logic [3:0] val;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a press is accepted after DC+1 consecutive samples of the same
    // non-zero pattern with habilita high; a release needs DC+1 consecutive zero samples.
    logic [3:0] m_d0 = 4'd0, m_d1 = 4'd0, m_val = 4'd0, m_jog = 4'd0;
    int m_fase = 0;
    int m_run = 0;
    int m_zrun = 0;

    always @(posedge clock) begin
        logic [3:0] bs;
        cyc++;
        if (reset) begin
            m_d0 = 4'd0; m_d1 = 4'd0; m_val = 4'd0; m_jog = 4'd0;
            m_fase = 0; m_run = 0; m_zrun = 0;
        end else begin
            bs   = m_d1;
            m_d1 = m_d0;
            m_d0 = botoes;
            case (m_fase)
                0: begin
                    if (m_run == 0) begin
                        if (habilita && bs != 4'd0) begin
                            m_run = 1;
                            m_val = bs;
                        end
                    end else if (habilita && bs == m_val) begin
                        m_run++;
                    end else begin
                        m_run = 0;
                    end
                    if (m_run == DC + 1) begin
                        sb.push_back('{valido: ($countones(m_val) == 1), val: m_val, cyc: cyc});
                        m_fase = 1;
                    end
                end
                1: begin
                    if ($countones(m_val) == 1) m_jog = m_val;
                    m_fase = 2;
                    m_zrun = 0;
                end
                default: begin
                    if (bs == 4'd0) m_zrun++;
                    else m_zrun = 0;
                    if (m_zrun == DC + 1) begin
                        m_fase = 0;
                        m_run = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (tem_jogada || jogada_invalida) begin
            check("pulse_exclusive", int'(tem_jogada && jogada_invalida), 0);
            check("pulse_queued", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_kind_valid", int'(tem_jogada), int'(e.valido));
            end
            if (tem_jogada) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
            end
        end
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse got none expected pulse at cycle %0d", e.cyc);
        end
        check("jogada_hold", int'(jogada), int'(m_jog));
    end

    task automatic drive(input logic [3:0] b, input logic h, input int n);
        botoes   = b;
        habilita = h;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_st [1:8];
        int p0;
        int t0;
        int n;
        bit seen;

        reset = 1'b1;
        botoes = 4'd0;
        habilita = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_db_estado", int'(db_estado), 0);
        check("rst_tem", int'(tem_jogada), 0);
        check("rst_inv", int'(jogada_invalida), 0);
        check("rst_jogada", int'(jogada), 0);
        reset = 1'b0;
        drive(4'd0, 1'b1, 3);

        // Clean press: state trace and latency
        exp_st = '{0, 0, 1, 1, 1, 1, 2, 3};
        p0 = pulse_cnt;
        t0 = cyc;
        botoes = 4'b0010;
        habilita = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            check($sformatf("clean_state_e%0d", e), int'(db_estado), exp_st[e]);
        end
        check("clean_pulse_cnt", pulse_cnt - p0, 1);
        check("clean_latency", last_pulse_cyc - t0, 7);
        check("clean_jogada", int'(jogada), 2);
        drive(4'd0, 1'b1, 12);

        // Bounce before a stable press
        p0 = pulse_cnt;
        drive(4'b0100, 1'b1, 2);
        drive(4'b0000, 1'b1, 1);
        t0 = cyc;
        drive(4'b0100, 1'b1, 12);
        check("bounce_pulse_cnt", pulse_cnt - p0, 1);
        check("bounce_latency", last_pulse_cyc - t0, 7);
        drive(4'd0, 1'b1, 12);

        // Multi-button press
        p0 = pulse_cnt;
        drive(4'b1001, 1'b1, 12);
        check("multi_no_valid", pulse_cnt - p0, 0);
        check("multi_jogada_kept", int'(jogada), 4);
        drive(4'd0, 1'b1, 12);

        // Held button, then a second press
        p0 = pulse_cnt;
        drive(4'b0001, 1'b1, 50);
        drive(4'd0, 1'b1, 12);
        drive(4'b0001, 1'b1, 12);
        drive(4'd0, 1'b1, 12);
        check("held_two_pulses", pulse_cnt - p0, 2);

        // Press while gated, then enable
        p0 = pulse_cnt;
        drive(4'b1000, 1'b0, 8);
        check("gated_state", int'(db_estado), 0);
        check("gated_no_pulse", pulse_cnt - p0, 0);
        t0 = cyc;
        drive(4'b1000, 1'b1, 8);
        check("gated_pulse_cnt", pulse_cnt - p0, 1);
        check("gated_latency", last_pulse_cyc - t0, 5);
        drive(4'd0, 1'b1, 12);

        // Reset while filtering a press
        p0 = pulse_cnt;
        botoes = 4'b0001;
        habilita = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clock);
            n++;
            if (db_estado == 3'd1) seen = 1'b1;
        end
        check("reach_filtra_press", int'(seen), 1);
        reset = 1'b1;
        botoes = 4'd0;
        @(negedge clock);
        check("midrst_state", int'(db_estado), 0);
        check("midrst_jogada", int'(jogada), 0);
        check("midrst_tem", int'(tem_jogada), 0);
        reset = 1'b0;
        drive(4'd0, 1'b1, 10);
        check("midrst_no_pulse", pulse_cnt - p0, 0);

        // Randomized traffic
        for (int s = 0; s < 300; s++) begin
            logic [3:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) b = 4'd0;
            else if (r < 8) b = 4'(1 << $urandom_range(0, 3));
            else b = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 49) == 0);
            drive(b, ($urandom_range(0, 7) != 0), 1);
            reset = 1'b0;
            repeat ($urandom_range(0, 11)) @(negedge clock);
        end

        drive(4'd0, 1'b1, 30);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
